// File: rtl/alu_8_sequencer.sv
// alu_8_sequencer: command FIFO feeding the 8-bit ALU, with registered result capture and divide-by-zero guard
module alu_8_sequencer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [3:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [8:0] alu_res,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [8:0] res,
    output logic       res_carry,
    output logic       res_zero,
    output logic       div_err
);
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0] q_op [DEPTH];
    logic [7:0] q_a [DEPTH];
    logic [7:0] q_b [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0] count;
    logic push, pop, cap, div0;
    assign cmd_ready = rst_n && (count < (ADDR_W+1)'(DEPTH));
    assign push = cmd_valid && cmd_ready;
    assign div0 = alu_op == 4'd3 && alu_b == 8'd0;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE  ? (count != 0 ? DRIVE : IDLE) :
                    state == DRIVE ? RESP :
                    res_ready      ? (count != 0 ? DRIVE : IDLE) : RESP;
    end
    // pop uses the pre-edge count, so a command pushed this cycle is never bypassed
    always_comb begin
        pop = count != 0 && (state == IDLE || (state == RESP && res_ready));
        cap = state == DRIVE;
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr] <= cmd_op;
            q_a[wr_ptr]  <= cmd_a;
            q_b[wr_ptr]  <= cmd_b;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            res       <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            div_err   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (pop) begin
                alu_op <= q_op[rd_ptr];
                alu_a  <= q_a[rd_ptr];
                alu_b  <= q_b[rd_ptr];
            end
            if (cap) begin
                res       <= div0 ? 9'd0 : alu_res;
                res_carry <= div0 ? 1'b0 : alu_carry;
                res_zero  <= div0 ? 1'b1 : alu_zero;
                div_err   <= div0;
            end
            res_valid <= cap || (res_valid && !res_ready);
        end
    end
endmodule

// File: tb/tb_alu_8_sequencer.sv
// tb_alu_8_sequencer: directed checks of queueing, latency, ordering, div guard and reset
module tb_alu_8_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [8:0] alu_res;
    logic       alu_carry;
    logic       alu_zero;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [8:0] res;
    logic       res_carry;
    logic       res_zero;
    logic       div_err;
    int pass_cnt = 0;
    int total = 0;

    alu_8_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res(res),
        .res_carry(res_carry), .res_zero(res_zero), .div_err(div_err)
    );

    always #5 clk = ~clk;

    // small ALU stand-in; divide-by-zero returns junk so the guard is exercised
    always_comb begin
        alu_res = 9'h000;
        case (alu_op)
            4'd0:    alu_res = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1:    alu_res = {1'b0, alu_a} - {1'b0, alu_b};
            4'd3:    alu_res = alu_b == 8'd0 ? 9'h1FF : {1'b0, alu_a / alu_b};
            4'd4:    alu_res = {1'b0, alu_a & alu_b};
            4'd10:   alu_res = {alu_a, 1'b0};
            default: alu_res = {8'd0, alu_a > alu_b};
        endcase
        alu_carry = alu_res[8];
        alu_zero  = alu_res == 9'h000;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        // reset held for three edges
        repeat (3) step();
        chk("rst_cmd_ready", {8'd0, cmd_ready}, 9'd0);
        chk("rst_res_valid", {8'd0, res_valid}, 9'd0);
        chk("rst_res", res, 9'd0);
        chk("rst_alu_op", {5'd0, alu_op}, 9'd0);
        chk("rst_div_err", {8'd0, div_err}, 9'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_cmd_ready", {8'd0, cmd_ready}, 9'd1);

        // ADD FF+01, latency two edges, valid for one cycle
        res_ready = 1'b1;
        send(4'd0, 8'hFF, 8'h01);
        chk("add_t0_valid", {8'd0, res_valid}, 9'd0);
        step();
        chk("add_t1_valid", {8'd0, res_valid}, 9'd0);
        chk("add_t1_alu_a", {1'b0, alu_a}, 9'h0FF);
        step();
        chk("add_t2_valid", {8'd0, res_valid}, 9'd1);
        chk("add_res", res, 9'h100);
        chk("add_carry", {8'd0, res_carry}, 9'd1);
        chk("add_zero", {8'd0, res_zero}, 9'd0);
        step();
        chk("add_t3_valid", {8'd0, res_valid}, 9'd0);

        // divide guard
        send(4'd3, 8'h10, 8'h00);
        step();
        step();
        chk("div0_valid", {8'd0, res_valid}, 9'd1);
        chk("div0_res", res, 9'd0);
        chk("div0_zero", {8'd0, res_zero}, 9'd1);
        chk("div0_carry", {8'd0, res_carry}, 9'd0);
        chk("div0_err", {8'd0, div_err}, 9'd1);
        step();
        send(4'd3, 8'h10, 8'h04);
        step();
        step();
        chk("div4_res", res, 9'h004);
        chk("div4_err", {8'd0, div_err}, 9'd0);
        chk("div4_zero", {8'd0, res_zero}, 9'd0);
        step();

        // stream of three with res_ready held high
        send(4'd1, 8'h05, 8'h03);
        send(4'd4, 8'hF0, 8'h3C);
        send(4'd10, 8'h81, 8'h00);
        chk("s1_valid", {8'd0, res_valid}, 9'd1);
        chk("s1_res", res, 9'h002);
        step();
        chk("s1_gap", {8'd0, res_valid}, 9'd0);
        step();
        chk("s2_res", res_valid ? res : 9'h1EE, 9'h030);
        step();
        chk("s2_gap", {8'd0, res_valid}, 9'd0);
        step();
        chk("s3_res", res_valid ? res : 9'h1EE, 9'h102);
        chk("s3_carry", {8'd0, res_carry}, 9'd1);
        step();
        chk("s3_done", {8'd0, res_valid}, 9'd0);

        // capacity: five accepted, sixth blocked until a slot frees
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cmd_valid = 1'b1;
            cmd_op = 4'd0;
            cmd_a = 8'(i);
            cmd_b = 8'h10;
            #0;
            chk("cap_ready", {8'd0, cmd_ready}, 9'd1);
            step();
        end
        cmd_a = 8'd6;
        chk("cap_full", {8'd0, cmd_ready}, 9'd0);
        chk("cap_held", res_valid ? res : 9'h1EE, 9'h011);
        step();
        chk("cap_still_full", {8'd0, cmd_ready}, 9'd0);
        chk("cap_still_held", res, 9'h011);
        res_ready = 1'b1;
        step();
        chk("cap_slot_free", {8'd0, cmd_ready}, 9'd1);
        chk("cap_gap", {8'd0, res_valid}, 9'd0);
        step();
        cmd_valid = 1'b0;
        chk("cap_r2", res_valid ? res : 9'h1EE, 9'h012);
        for (int k = 3; k <= 6; k++) begin
            step();
            chk("cap_gap_k", {8'd0, res_valid}, 9'd0);
            step();
            chk("cap_rk", res_valid ? res : 9'h1EE, 9'(9'h010 + k));
        end
        step();
        chk("cap_drained", {8'd0, res_valid}, 9'd0);

        // reset with three queued and a result held
        res_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(4'd0, 8'(i), 8'h01);
        chk("mid_valid", {8'd0, res_valid}, 9'd1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", {8'd0, res_valid}, 9'd0);
        chk("mid_rst_ready", {8'd0, cmd_ready}, 9'd0);
        chk("mid_rst_res", res, 9'd0);
        rst_n = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("mid_rel_ready", {8'd0, cmd_ready}, 9'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_no_result", {8'd0, res_valid}, 9'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
